spike_rate_encoder: RTL

Converts one signed fixed-point activation into a deterministic rate-coded spike train for the spiking PE array: `out_spike` drives a PE `in_spike`, and `out_polarity` drives its `in_polarity`. A value is accepted over a valid/ready handshake. Over `num_steps` timesteps, each advanced by `step_en`, the block emits one spike/no-spike decision per step. Spike density is |value| / 2^(DATA_W-1), produced by a first-order sigma-delta accumulator.

---
 rtl/spike_enc_pkg.sv | 17 +
 rtl/spike_sigma_delta.sv | 37 +++
 rtl/spike_rate_encoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spike_enc_pkg.sv
// Shared types and constants for the spike rate encoder.
// Polarity support is controlled by the SPIKE_ENC_POLARITY_EN macro in spike_rate_encoder.
package spike_enc_pkg;

  localparam int SPIKE_DATA_W = 16;
  localparam int SPIKE_T_W    = 8;

  // Largest representable positive magnitude at the default width.
  localparam logic [SPIKE_DATA_W-1:0] MAG_MAX = {1'b0, {(SPIKE_DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/spike_sigma_delta.sv
// First-order sigma-delta core: holds the magnitude and the accumulator and
// produces one spike decision per step from the accumulator MSB.
module spike_sigma_delta
  import spike_enc_pkg::*;
#(
  parameter int DATA_W = SPIKE_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [DATA_W-1:0] mag,
  input  logic              step,
  output logic              spike
);

  logic [DATA_W-1:0] mag_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] sum;

  // acc stays below 2^(DATA_W-1) and mag is at most 2^(DATA_W-1)-1, so the
  // sum cannot wrap; its MSB is exactly the carry-out of the lower bits.
  assign sum   = acc_reg + mag_reg;
  assign spike = sum[DATA_W-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mag_reg <= '0;
      acc_reg <= '0;
    end else if (load) begin
      mag_reg <= mag;
      acc_reg <= '0;
    end else if (step) begin
      acc_reg <= {1'b0, sum[DATA_W-2:0]};
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes one signed Q1.(DATA_W-1) activation into num_steps spike decisions.
// Define SPIKE_ENC_POLARITY_EN to encode negative values as inhibitory spikes.
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter int DATA_W = SPIKE_DATA_W,
  parameter int T_W    = SPIKE_T_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_value,
  input  logic        [T_W-1:0]    num_steps,
  input  logic                     step_en,
  output logic                     out_valid,
  output logic                     out_spike,
  output logic                     out_polarity,
  output logic                     out_last,
  output logic                     done,
  output logic                     busy
);

  localparam logic [DATA_W-1:0] MAG_SAT = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] VAL_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  enc_state_t        state_reg, state_next;
  logic [T_W-1:0]    cnt_reg, cnt_next;
  logic              sign_reg, sign_next;
  logic              out_valid_reg, out_valid_next;
  logic              out_spike_reg, out_spike_next;
  logic              out_polarity_reg, out_polarity_next;
  logic              out_last_reg, out_last_next;
  logic              done_reg, done_next;

  logic [DATA_W-1:0] mag_in;
  logic              sign_in;
  logic              sd_load;
  logic              sd_step;
  logic              sd_spike;

`ifdef SPIKE_ENC_POLARITY_EN
  always_comb begin
    sign_in = in_value[DATA_W-1];
    if ($unsigned(in_value) == VAL_MIN) begin
      mag_in = MAG_SAT;
    end else if (sign_in) begin
      mag_in = DATA_W'(-in_value);
    end else begin
      mag_in = $unsigned(in_value);
    end
  end
`else
  // Without polarity support, negative activations are silent.
  always_comb begin
    sign_in = 1'b0;
    mag_in  = in_value[DATA_W-1] ? '0 : $unsigned(in_value);
  end
`endif

  spike_sigma_delta #(
    .DATA_W(DATA_W)
  ) u_sigma_delta (
    .clk  (clk),
    .rstn (rstn),
    .load (sd_load),
    .mag  (mag_in),
    .step (sd_step),
    .spike(sd_spike)
  );

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    sign_next         = sign_reg;
    out_valid_next    = 1'b0;
    out_spike_next    = 1'b0;
    out_polarity_next = 1'b0;
    out_last_next     = 1'b0;
    done_next         = 1'b0;
    sd_load           = 1'b0;
    sd_step           = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sd_load   = 1'b1;
          sign_next = sign_in;
          cnt_next  = num_steps;
          if (num_steps == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (step_en) begin
          sd_step           = 1'b1;
          cnt_next          = cnt_reg - 1'b1;
          out_valid_next    = 1'b1;
          out_spike_next    = sd_spike;
          out_polarity_next = sd_spike & sign_reg;
          out_last_next     = (cnt_reg == T_W'(1));
          if (cnt_reg == T_W'(1)) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      sign_reg         <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_spike_reg    <= 1'b0;
      out_polarity_reg <= 1'b0;
      out_last_reg     <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      sign_reg         <= sign_next;
      out_valid_reg    <= out_valid_next;
      out_spike_reg    <= out_spike_next;
      out_polarity_reg <= out_polarity_next;
      out_last_reg     <= out_last_next;
      done_reg         <= done_next;
    end
  end

  assign in_ready     = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign out_valid    = out_valid_reg;
  assign out_spike    = out_spike_reg;
  assign out_polarity = out_polarity_reg;
  assign out_last     = out_last_reg;
  assign done         = done_reg;

endmodule
